// File: rtl/pinmux_pad_attr_ctrl.sv
// Pad attribute controller: WARL-masked per-pad attribute registers with apply/settle write sequencing.
// Optional sticky per-pad write lock enabled by defining PAD_ATTR_LOCK_EN.
module pinmux_pad_attr_ctrl #(
   parameter int NumPads      = 4,
   parameter int AttrW        = 8,
   parameter int PadType      = 2,
   parameter int SettleCycles = 3
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         req_i,
   input  logic                         we_i,
   input  logic [$clog2(NumPads+1)-1:0] pad_idx_i,
   input  logic [AttrW-1:0]             wdata_i,
   output logic                         gnt_o,
   output logic                         rvalid_o,
   output logic [AttrW-1:0]             rdata_o,
   output logic                         err_o,
   output logic                         busy_o,
   output logic [NumPads*AttrW-1:0]     pad_attr_o
);

   localparam int IdxW = $clog2(NumPads + 1);
   localparam int CntW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
   localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumPads);
   localparam logic [CntW-1:0]  CntLast  = CntW'((SettleCycles > 0) ? SettleCycles - 1 : 0);
   localparam logic [AttrW-1:0] AttrMask = (PadType == 1) ? AttrW'(3) :
                                           (PadType == 2) ? {AttrW{1'b1}} : {AttrW{1'b0}};

   typedef enum logic [1:0] {IDLE, APPLY, SETTLE, RESP} state_t;

   state_t            state_reg, state_next;
   logic              we_reg;
   logic              err_reg;
   logic [IdxW-1:0]   idx_reg;
   logic [AttrW-1:0]  wdata_reg;
   logic [AttrW-1:0]  wdata_next;
   logic [CntW-1:0]   cnt_reg;
   logic [NumPads*AttrW-1:0] attr_bus;
   logic [AttrW-1:0]  rd_sel;
   logic              gnt;
   logic              req_err;
   logic              lock_sel;
   logic              apply_pad;

   // Gated by rst_ni so a request held across reset is never granted while reset is asserted.
   assign gnt = req_i & rst_ni & (state_reg == IDLE);

`ifdef PAD_ATTR_LOCK_EN
   logic [NumPads-1:0] lock_reg;
   logic [NumPads-1:0] lock_wdata;
   logic [AttrW-1:0]   lock_rdata;
   logic               idx_locked;

   always_comb begin
      idx_locked = 1'b0;
      for (int k = 0; k < NumPads; k++) begin
         if (pad_idx_i == IdxW'(k)) begin
            idx_locked = lock_reg[k];
         end
      end
   end

   assign req_err    = (pad_idx_i > LastIdx) | (we_i & idx_locked);
   assign lock_sel   = (idx_reg == LastIdx);
   // The lock index keeps the raw write data; pad writes are WARL-masked.
   assign wdata_next = (pad_idx_i == LastIdx) ? wdata_i : (wdata_i & AttrMask);

   generate
      for (genvar gi = 0; gi < NumPads; gi++) begin : g_lock_w
         if (gi < AttrW) begin : g_bit
            assign lock_wdata[gi] = wdata_reg[gi];
         end else begin : g_zero
            assign lock_wdata[gi] = 1'b0;
         end
      end
      for (genvar gi = 0; gi < AttrW; gi++) begin : g_lock_r
         if (gi < NumPads) begin : g_bit
            assign lock_rdata[gi] = lock_reg[gi];
         end else begin : g_zero
            assign lock_rdata[gi] = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_reg <= '0;
      end else if (state_reg == APPLY && lock_sel) begin
         lock_reg <= lock_reg | lock_wdata;
      end
   end
`else
   assign req_err    = (pad_idx_i >= LastIdx);
   assign lock_sel   = 1'b0;
   assign wdata_next = wdata_i & AttrMask;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (gnt) begin
               state_next = (we_i && !req_err) ? APPLY : RESP;
            end
         end
         APPLY:   state_next = (SettleCycles > 0) ? SETTLE : RESP;
         SETTLE: begin
            if (cnt_reg == CntLast) begin
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         we_reg    <= 1'b0;
         err_reg   <= 1'b0;
         idx_reg   <= '0;
         wdata_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (gnt) begin
            we_reg    <= we_i;
            err_reg   <= req_err;
            idx_reg   <= pad_idx_i;
            wdata_reg <= wdata_next;
            cnt_reg   <= '0;
         end else if (state_reg == SETTLE) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign apply_pad = (state_reg == APPLY) & ~lock_sel;

   generate
      for (genvar gi = 0; gi < NumPads; gi++) begin : g_pad
         logic [AttrW-1:0] attr_reg;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               attr_reg <= '0;
            end else if (apply_pad && idx_reg == IdxW'(gi)) begin
               attr_reg <= wdata_reg;
            end
         end
         assign attr_bus[gi*AttrW +: AttrW] = attr_reg;
      end
   endgenerate

   always_comb begin
      rd_sel = '0;
      for (int k = 0; k < NumPads; k++) begin
         if (idx_reg == IdxW'(k)) begin
            rd_sel = attr_bus[k*AttrW +: AttrW];
         end
      end
`ifdef PAD_ATTR_LOCK_EN
      if (idx_reg == LastIdx) begin
         rd_sel = lock_rdata;
      end
`endif
   end

   assign gnt_o      = gnt;
   assign rvalid_o   = (state_reg == RESP);
   assign err_o      = (state_reg == RESP) & err_reg;
   assign rdata_o    = ((state_reg == RESP) && !we_reg && !err_reg) ? rd_sel : '0;
   assign busy_o     = (state_reg != IDLE);
   assign pad_attr_o = attr_bus;

endmodule
